axi_lite_write_slave: RTL and testbench



---
 rtl/axi_lite_write_slave_if.sv | 24 ++
 rtl/axi_lite_write_slave.sv | 124 ++++++++++++
 tb/tb_axi_lite_write_slave.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_write_slave_if.sv
// AXI4-Lite write-channel bundle (AW, W, B) shared between a manager and
// the axi_lite_write_slave responder. Signal names follow the AXI spelling.
interface axi_lite_write_slave_if;
   logic [31:0] AWADDR;
   logic        AWVALID;
   logic        AWREADY;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        WVALID;
   logic        WREADY;
   logic [1:0]  BRESP;
   logic        BVALID;
   logic        BREADY;

   modport master (
      output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
      input  AWREADY, WREADY, BRESP, BVALID
   );

   modport slave (
      input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
      output AWREADY, WREADY, BRESP, BVALID
   );
endinterface

// File: rtl/axi_lite_write_slave.sv
// AXI4-Lite write responder with a byte-strobed register bank.
// AW and W are accepted independently into one-entry buffers; the write
// commits once both are present, then a single B response is held until
// BREADY. At most one write is in flight.
// Build option: define AXI_WR_SLVERR_EN to answer out-of-range writes with
// SLVERR instead of OKAY (the write is dropped either way).
module axi_lite_write_slave #(
   parameter int NUM_REGS = 16,
   localparam int IDX_W = $clog2(NUM_REGS)
) (
   input  logic                 ACLK,
   input  logic                 ARESETn,
   axi_lite_write_slave_if.slave bus,
   input  logic [IDX_W-1:0]     rf_raddr,
   output logic [31:0]          rf_rdata
);

   localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI_WR_SLVERR_EN
   localparam logic [1:0] RESP_OOR = 2'b10;
`else
   localparam logic [1:0] RESP_OOR = 2'b00;
`endif
   localparam logic [31:0] ADDR_LIMIT = 32'(NUM_REGS * 4);

   logic [31:0]      regs [NUM_REGS];

   logic             rdy_en;
   logic             aw_full;
   logic             aw_in_range;
   logic [IDX_W-1:0] aw_idx;
   logic             w_full;
   logic [31:0]      w_buf;
   logic [3:0]       s_buf;
   logic             bvalid_q;
   logic [1:0]       bresp_q;

   logic             aw_ready;
   logic             w_ready;
   logic             aw_hs;
   logic             w_hs;
   logic             commit;
   logic             cur_in_range;
   logic [IDX_W-1:0] cur_idx;
   logic [31:0]      cur_data;
   logic [3:0]       cur_strb;
   logic             unused_addr_bits;

   // The AW buffer keeps the decoded index and range flag, so the byte
   // offset bits are never needed.
   assign unused_addr_bits = ^bus.AWADDR[1:0];

   assign aw_ready = rdy_en & ~aw_full & ~bvalid_q;
   assign w_ready  = rdy_en & ~w_full & ~bvalid_q;
   assign aw_hs    = bus.AWVALID & aw_ready;
   assign w_hs     = bus.WVALID & w_ready;

   // Each side is available if buffered earlier or handshaking right now.
   assign commit       = (aw_full | aw_hs) & (w_full | w_hs);
   assign cur_in_range = aw_full ? aw_in_range : (bus.AWADDR < ADDR_LIMIT);
   assign cur_idx      = aw_full ? aw_idx : bus.AWADDR[IDX_W+1:2];
   assign cur_data     = w_full ? w_buf : bus.WDATA;
   assign cur_strb     = w_full ? s_buf : bus.WSTRB;

   assign bus.AWREADY = aw_ready;
   assign bus.WREADY  = w_ready;
   assign bus.BVALID  = bvalid_q;
   assign bus.BRESP   = bresp_q;

   assign rf_rdata = regs[rf_raddr];

   // Channel buffers, ready enable and B response registers.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         rdy_en      <= 1'b0;
         aw_full     <= 1'b0;
         aw_in_range <= 1'b0;
         aw_idx      <= '0;
         w_full      <= 1'b0;
         w_buf       <= '0;
         s_buf       <= '0;
         bvalid_q    <= 1'b0;
         bresp_q     <= RESP_OKAY;
      end else begin
         rdy_en <= 1'b1;
         if (commit) begin
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            bvalid_q <= 1'b1;
            bresp_q  <= cur_in_range ? RESP_OKAY : RESP_OOR;
         end else begin
            if (aw_hs) begin
               aw_full     <= 1'b1;
               aw_in_range <= bus.AWADDR < ADDR_LIMIT;
               aw_idx      <= bus.AWADDR[IDX_W+1:2];
            end
            if (w_hs) begin
               w_full <= 1'b1;
               w_buf  <= bus.WDATA;
               s_buf  <= bus.WSTRB;
            end
            if (bvalid_q && bus.BREADY) begin
               bvalid_q <= 1'b0;
            end
         end
      end
   end

   // Register bank: strobed byte writes at the commit edge, cleared on reset.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            regs[r] <= '0;
         end
      end else if (commit && cur_in_range) begin
         for (int i = 0; i < 4; i++) begin
            if (cur_strb[i]) begin
               regs[cur_idx][8*i +: 8] <= cur_data[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_axi_lite_write_slave.sv
// Self-checking bench for axi_lite_write_slave: reset behaviour, a table of
// directed writes with hand-computed results, a reset-mid-transaction
// sequence, and randomized writes checked against a byte-array model.
// Honours AXI_WR_SLVERR_EN for the expected out-of-range response.
module tb_axi_lite_write_slave;

   localparam int NUM_REGS = 16;
   localparam int IDX_W    = 4;
`ifdef AXI_WR_SLVERR_EN
   localparam logic [1:0] OOR_RESP = 2'b10;
`else
   localparam logic [1:0] OOR_RESP = 2'b00;
`endif

   logic              clk = 1'b0;
   logic              rst_n;
   logic [IDX_W-1:0]  rf_raddr;
   logic [31:0]       rf_rdata;
   int                checks = 0;
   int                errors = 0;
   logic [31:0]       model [NUM_REGS];

   axi_lite_write_slave_if bus ();

   axi_lite_write_slave #(.NUM_REGS(NUM_REGS)) dut (
      .ACLK     (clk),
      .ARESETn  (rst_n),
      .bus      (bus),
      .rf_raddr (rf_raddr),
      .rf_rdata (rf_rdata)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]      addr;
      logic [31:0]      data;
      logic [3:0]       strb;
      int               aw_dly;
      int               w_dly;
      int               b_dly;
      logic [IDX_W-1:0] exp_idx;
      logic [31:0]      exp_reg;
      logic [1:0]       exp_resp;
   } vec_t;

   vec_t vecs [7];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic peek(input int idx, output logic [31:0] val);
      rf_raddr = IDX_W'(idx);
      #1;
      val = rf_rdata;
   endtask

   function automatic logic [1:0] respFor(input logic [31:0] addr);
      return (addr < NUM_REGS * 4) ? 2'b00 : OOR_RESP;
   endfunction

   // Reference write: in-range byte lanes with strobe set take the new data.
   task automatic modelWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      int idx;
      if (addr < NUM_REGS * 4) begin
         idx = int'(addr / 4);
         for (int i = 0; i < 4; i++) begin
            if (strb[i]) model[idx][8*i +: 8] = data[8*i +: 8];
         end
      end
   endtask

   // One full write: AW after aw_dly cycles, W after w_dly cycles, BREADY held
   // low for b_dly cycles once BVALID rises (b_dly=0 keeps BREADY high).
   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                                input logic [3:0] strb, input int aw_dly, input int w_dly,
                                input int b_dly, input logic [1:0] exp_resp);
      int cyc;
      bit aw_done, w_done, aw_hs, w_hs;
      aw_done = 0;
      w_done  = 0;
      cyc     = 0;
      while (!(aw_done && w_done) && cyc < 40) begin
         if (aw_done) checkOutput("awready_wait", bus.AWREADY, 0);
         if (w_done)  checkOutput("wready_wait", bus.WREADY, 0);
         bus.AWADDR  = addr;
         bus.AWVALID = !aw_done && cyc >= aw_dly;
         bus.WDATA   = data;
         bus.WSTRB   = strb;
         bus.WVALID  = !w_done && cyc >= w_dly;
         bus.BREADY  = (b_dly == 0);
         aw_hs = bus.AWVALID && bus.AWREADY;
         w_hs  = bus.WVALID && bus.WREADY;
         step();
         aw_done = aw_done || aw_hs;
         w_done  = w_done || w_hs;
         cyc++;
      end
      bus.AWVALID = 1'b0;
      bus.WVALID  = 1'b0;
      if (!(aw_done && w_done)) begin
         checkOutput("handshake_timeout", 0, 1);
         return;
      end
      checkOutput("bvalid_rise", bus.BVALID, 1);
      checkOutput("bresp", bus.BRESP, exp_resp);
      for (int k = 0; k < b_dly; k++) begin
         checkOutput("bvalid_hold", bus.BVALID, 1);
         checkOutput("bresp_hold", bus.BRESP, exp_resp);
         checkOutput("awready_bp", bus.AWREADY, 0);
         checkOutput("wready_bp", bus.WREADY, 0);
         step();
      end
      bus.BREADY = 1'b1;
      step();
      checkOutput("bvalid_fall", bus.BVALID, 0);
      checkOutput("awready_back", bus.AWREADY, 1);
      checkOutput("wready_back", bus.WREADY, 1);
      bus.BREADY = 1'b0;
   endtask

   initial begin
      logic [31:0] val;
      logic [31:0] r_addr, r_data;
      logic [3:0]  r_strb;

      // Directed vectors with hand-computed register contents.
      vecs[0] = '{32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0, 4'd2,  32'hDEADBEEF, 2'b00};
      vecs[1] = '{32'h08, 32'h11223344, 4'h5, 3, 0, 0, 4'd2,  32'hDE22BE44, 2'b00};
      vecs[2] = '{32'h0C, 32'hA5A5A5A5, 4'h8, 0, 2, 5, 4'd3,  32'hA5000000, 2'b00};
      vecs[3] = '{32'h40, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 4'd0,  32'h00000000, OOR_RESP};
      vecs[4] = '{32'h3F, 32'h12345678, 4'h3, 1, 0, 2, 4'd15, 32'h00005678, 2'b00};
      vecs[5] = '{32'h04, 32'hCAFEF00D, 4'h0, 0, 0, 0, 4'd1,  32'h00000000, 2'b00};
      vecs[6] = '{32'h04, 32'hCAFEF00D, 4'h6, 2, 2, 1, 4'd1,  32'h00FEF000, 2'b00};

      for (int r = 0; r < NUM_REGS; r++) model[r] = '0;
      rst_n       = 1'b0;
      rf_raddr    = '0;
      bus.AWADDR  = '0;
      bus.AWVALID = 1'b0;
      bus.WDATA   = '0;
      bus.WSTRB   = '0;
      bus.WVALID  = 1'b0;
      bus.BREADY  = 1'b0;

      // Reset held for three cycles.
      repeat (3) begin
         @(negedge clk);
         checkOutput("rst_bvalid", bus.BVALID, 0);
         checkOutput("rst_bresp", bus.BRESP, 0);
         checkOutput("rst_awready", bus.AWREADY, 0);
         checkOutput("rst_wready", bus.WREADY, 0);
      end
      rst_n = 1'b1;
      #1;
      checkOutput("rel_awready", bus.AWREADY, 0);
      step();
      checkOutput("rel2_awready", bus.AWREADY, 1);
      checkOutput("rel2_wready", bus.WREADY, 1);
      for (int r = 0; r < NUM_REGS; r++) begin
         peek(r, val);
         checkOutput("rst_bank", val, 0);
      end
      @(negedge clk);

      // Directed table.
      for (int v = 0; v < 7; v++) begin
         applyStimulus(vecs[v].addr, vecs[v].data, vecs[v].strb, vecs[v].aw_dly,
                       vecs[v].w_dly, vecs[v].b_dly, vecs[v].exp_resp);
         modelWrite(vecs[v].addr, vecs[v].data, vecs[v].strb);
         peek(int'(vecs[v].exp_idx), val);
         checkOutput($sformatf("vec%0d_reg", v), val, vecs[v].exp_reg);
         @(negedge clk);
      end
      for (int r = 0; r < NUM_REGS; r++) begin
         peek(r, val);
         checkOutput("table_bank", val, model[r]);
      end
      @(negedge clk);

      // Reset between AW and W discards the buffered address.
      bus.AWADDR  = 32'h10;
      bus.AWVALID = 1'b1;
      checkOutput("mid_awready", bus.AWREADY, 1);
      step();
      bus.AWVALID = 1'b0;
      checkOutput("mid_aw_buffered", bus.AWREADY, 0);
      rst_n = 1'b0;
      step();
      checkOutput("mid_rst_bvalid", bus.BVALID, 0);
      rst_n = 1'b1;
      for (int r = 0; r < NUM_REGS; r++) model[r] = '0;
      step();
      checkOutput("mid_rel_awready", bus.AWREADY, 1);
      checkOutput("mid_rel_bvalid", bus.BVALID, 0);
      bus.WDATA  = 32'h55AA55AA;
      bus.WSTRB  = 4'hF;
      bus.WVALID = 1'b1;
      checkOutput("mid_wready", bus.WREADY, 1);
      step();
      bus.WVALID = 1'b0;
      repeat (3) begin
         checkOutput("mid_no_b", bus.BVALID, 0);
         checkOutput("mid_w_buffered", bus.WREADY, 0);
         checkOutput("mid_aw_open", bus.AWREADY, 1);
         step();
      end
      peek(4, val);
      checkOutput("mid_reg4", val, 0);
      @(negedge clk);
      bus.AWADDR  = 32'h14;
      bus.AWVALID = 1'b1;
      step();
      bus.AWVALID = 1'b0;
      modelWrite(32'h14, 32'h55AA55AA, 4'hF);
      checkOutput("mid_bvalid", bus.BVALID, 1);
      checkOutput("mid_bresp", bus.BRESP, 0);
      peek(5, val);
      checkOutput("mid_reg5", val, 32'h55AA55AA);
      @(negedge clk);
      bus.BREADY = 1'b1;
      step();
      checkOutput("mid_bvalid_fall", bus.BVALID, 0);
      bus.BREADY = 1'b0;

      // Randomized writes against the model, including out-of-range addresses.
      for (int n = 0; n < 40; n++) begin
         r_addr = 32'($urandom_range(0, 79));
         r_data = $urandom;
         r_strb = 4'($urandom_range(0, 15));
         applyStimulus(r_addr, r_data, r_strb, int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), respFor(r_addr));
         modelWrite(r_addr, r_data, r_strb);
         peek(int'((r_addr / 4) % NUM_REGS), val);
         checkOutput("rand_reg", val, model[(r_addr / 4) % NUM_REGS]);
         @(negedge clk);
      end
      for (int r = 0; r < NUM_REGS; r++) begin
         peek(r, val);
         checkOutput("final_bank", val, model[r]);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
